// File: rtl/mdu_hilo_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
// The master is the pipeline side. The slave is the mdu_hilo unit.
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// It takes WIDTH steps per operation. HI and LO update only on completion, on MTHI/MTLO, or on reset.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    mdu_hilo_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {sIdle, sRun} mduState_t;

    mduState_t        state;
    logic [CW-1:0]    cnt;
    logic             isDiv;
    logic             negRes;
    logic             negRem;
    logic             divZero;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic             busyReg;
    logic             doneReg;

    logic             aNeg;
    logic             bNeg;
    logic [WIDTH:0]   prodSum;
    logic [WIDTH:0]   divShift;
    logic             divGe;
    logic [WIDTH-1:0] divDiff;
    logic [WIDTH-1:0] nextHi;
    logic [WIDTH-1:0] nextLo;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0] resHi;
    logic [WIDTH-1:0] resLo;

    assign bus.busy = busyReg;
    assign bus.done = doneReg;
    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;

    // For the multiply, accHi:accLo is the product and accLo initially holds the multiplier.
    // For the divide, accHi is the partial remainder and accLo shifts the dividend out and the quotient in.
    always_comb begin
        aNeg     = ~bus.op[0] & bus.rs_data[WIDTH-1];
        bNeg     = ~bus.op[0] & bus.rt_data[WIDTH-1];
        prodSum  = {1'b0, accHi} + {1'b0, (accLo[0] ? aMag : {WIDTH{1'b0}})};
        divShift = {accHi, accLo[WIDTH-1]};
        divGe    = divShift >= {1'b0, bMag};
        divDiff  = divShift[WIDTH-1:0] - bMag;
        if (isDiv) begin
            nextHi = divGe ? divDiff : divShift[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], divGe};
        end else begin
            nextHi = prodSum[WIDTH:1];
            nextLo = {prodSum[0], accLo[WIDTH-1:1]};
        end
        product = {nextHi, nextLo};
        prodFix = negRes ? -product : product;
        // Divide by zero leaves the dividend magnitude as the remainder.
        // Applying the dividend sign to it gives back the original rs_data.
        if (isDiv) begin
            resHi = negRem ? -nextHi : nextHi;
            resLo = divZero ? {WIDTH{1'b1}} : (negRes ? -nextLo : nextLo);
        end else begin
            resHi = prodFix[2*WIDTH-1:WIDTH];
            resLo = prodFix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= sIdle;
            cnt     <= '0;
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            aMag    <= '0;
            bMag    <= '0;
            accHi   <= '0;
            accLo   <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                sIdle: begin
                    if (bus.start) begin
                        state   <= sRun;
                        cnt     <= '0;
                        busyReg <= 1'b1;
                        isDiv   <= bus.op[1];
                        negRes  <= aNeg ^ bNeg;
                        negRem  <= aNeg;
                        divZero <= (bus.rt_data == '0);
                        aMag    <= aNeg ? -bus.rs_data : bus.rs_data;
                        bMag    <= bNeg ? -bus.rt_data : bus.rt_data;
                        accHi   <= '0;
                        if (bus.op[1]) accLo <= aNeg ? -bus.rs_data : bus.rs_data;
                        else           accLo <= bNeg ? -bus.rt_data : bus.rt_data;
                    end else begin
                        if (bus.mthi) hiReg <= bus.wdata;
                        if (bus.mtlo) loReg <= bus.wdata;
                    end
                end
                sRun: begin
                    accHi <= nextHi;
                    accLo <= nextLo;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        hiReg   <= resHi;
                        loReg   <= resLo;
                        doneReg <= 1'b1;
                        busyReg <= 1'b0;
                        state   <= sIdle;
                    end
                end
                default: state <= sIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed-vector bench for mdu_hilo, checking the 32-cycle latency, sign handling and HI/LO write rules.
module tb_mdu_hilo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nVec = 0;
    int   nMiss = 0;

    mdu_hilo_if #(.WIDTH(32)) bus ();

    mdu_hilo #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Call this task at a negedge. Inputs are driven there, so start is sampled at the next posedge (E0).
    // The task returns at the negedge after E32, the cycle in which done should be high.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo, input bit disturb);
        logic [31:0] oldHi, oldLo;
        int busyCnt, doneCnt, stableBad;
        oldHi = bus.hi;
        oldLo = bus.lo;
        bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.rs_data = 32'h0BAD_F00D; bus.rt_data = 32'h0000_0003;
        busyCnt = 0; doneCnt = 0; stableBad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (disturb && i == 5) begin
                bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd3; bus.rt_data = 32'd4;
                bus.mtlo = 1'b1; bus.wdata = 32'h5555;
            end else begin
                bus.start = 1'b0; bus.mtlo = 1'b0;
            end
            busyCnt += int'(bus.busy);
            doneCnt += int'(bus.done);
            if (bus.hi !== oldHi || bus.lo !== oldLo) stableBad++;
        end
        bus.start = 1'b0; bus.mtlo = 1'b0;
        @(negedge clk);
        chk({tag, " busy cycles"}, 64'(busyCnt), 64'd32);
        chk({tag, " early done"}, 64'(doneCnt), 64'd0);
        chk({tag, " hilo mid-run"}, 64'(stableBad), 64'd0);
        chk({tag, " done"}, {63'd0, bus.done}, 64'd1);
        chk({tag, " busy end"}, {63'd0, bus.busy}, 64'd0);
        chk({tag, " hi"}, {32'd0, bus.hi}, {32'd0, expHi});
        chk({tag, " lo"}, {32'd0, bus.lo}, {32'd0, expLo});
    endtask

    initial begin
        int doneSeen;
        bus.start = 1'b0; bus.op = 2'b00; bus.rs_data = '0; bus.rt_data = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst hi", {32'd0, bus.hi}, 64'd0);
        chk("rst lo", {32'd0, bus.lo}, 64'd0);
        chk("rst busy", {63'd0, bus.busy}, 64'd0);
        chk("rst done", {63'd0, bus.done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // These operations run back to back, so each start is sampled at E33 of the previous operation.
        runOp("multu ffff^2", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        runOp("mult -3*5",    2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        runOp("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        runOp("div -7/2",     2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        runOp("div 7/-2",     2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        runOp("div ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        runOp("divu x/0",     2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
        runOp("div -7/0",     2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);

        @(negedge clk);
        chk("done single pulse", {63'd0, bus.done}, 64'd0);

        bus.mthi = 1'b1; bus.wdata = 32'h0000_AAAA;
        @(negedge clk);
        bus.mthi = 1'b0;
        chk("mthi hi", {32'd0, bus.hi}, 64'h0000_AAAA);
        chk("mthi lo kept", {32'd0, bus.lo}, 64'hFFFF_FFFF);

        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h0000_1357;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        chk("mthi+mtlo hi", {32'd0, bus.hi}, 64'h0000_1357);
        chk("mthi+mtlo lo", {32'd0, bus.lo}, 64'h0000_1357);

        // If start and mthi are issued together, start wins. The mid-run hold check then catches a leaked write.
        bus.mthi = 1'b1; bus.wdata = 32'h0000_DEAD;
        runOp("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);

        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd7; bus.rt_data = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("multu busy pre-rst", {63'd0, bus.busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", {63'd0, bus.busy}, 64'd0);
        chk("abort done", {63'd0, bus.done}, 64'd0);
        chk("abort hi", {32'd0, bus.hi}, 64'd0);
        chk("abort lo", {32'd0, bus.lo}, 64'd0);
        rst = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            doneSeen += int'(bus.done);
        end
        chk("no done after abort", 64'(doneSeen), 64'd0);
        chk("idle busy after abort", {63'd0, bus.busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end
endmodule
